// File: rtl/boss_hit_arbiter.sv
// Boss damage judge: tests N bullets against the boss hitbox, consumes hits,
// applies one damage point per hit cycle and runs ALIVE/INVULN/BOOM/REVIVE.
// Ports: clk, rst (async, active-high); boss_x/boss_y/boss_en boss pose;
//   bul_x/bul_y/bul_vld packed bullet channels; bul_kill per-bullet consume
//   pulse; hit damage pulse; hp health; boom/revive/invuln state flags.
module boss_hit_arbiter #(
  parameter int N_BUL    = 4,
  parameter int CW       = 10,
  parameter int HP_W     = 4,
  parameter int HP_MAX   = 10,
  parameter int BOSS_W   = 128,
  parameter int BOSS_H   = 128,
  parameter int BUL_W    = 10,
  parameter int BUL_H    = 40,
  parameter int Y_OFS    = 480,
  parameter int INV_CYC  = 150000,
  parameter int BOOM_CYC = 2000000,
  parameter int REV_CYC  = 375000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CW-1:0]       boss_x,
  input  logic [CW-1:0]       boss_y,
  input  logic                boss_en,
  input  logic [N_BUL*CW-1:0] bul_x,
  input  logic [N_BUL*CW-1:0] bul_y,
  input  logic [N_BUL-1:0]    bul_vld,
  output logic [N_BUL-1:0]    bul_kill,
  output logic                hit,
  output logic [HP_W-1:0]     hp,
  output logic                boom,
  output logic                revive,
  output logic                invuln
);

  localparam int AW = CW + 2;

  typedef enum logic [1:0] {
    S_ALIVE,
    S_INVULN,
    S_BOOM,
    S_REVIVE
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       timer_q, timer_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              hit_q, hit_d;
  logic [N_BUL-1:0]  kill_q, kill_d;

  logic [AW-1:0]     y_org;
  logic [AW-1:0]     x_lo, x_hi;
  logic [AW-1:0]     y_lo, y_hi;
  logic              det_en;
  logic [N_BUL-1:0]  hit_vec;

  // Hitbox bounds at CW+2 bits so neither the offset nor the
  // margins can wrap; the low bounds clamp at zero.
  always_comb begin
    y_org = AW'(boss_y) + AW'(Y_OFS);
    x_lo  = (AW'(boss_x) >= AW'(BUL_W)) ?
            AW'(boss_x) - AW'(BUL_W) : '0;
    x_hi  = AW'(boss_x) + AW'(BOSS_W);
    y_lo  = (y_org >= AW'(BUL_H)) ?
            y_org - AW'(BUL_H) : '0;
    y_hi  = y_org + AW'(BOSS_H);
  end

  assign det_en = boss_en &
                  ((state_q == S_ALIVE) | (state_q == S_INVULN));

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < N_BUL; i++) begin
      hit_vec[i] = bul_vld[i] & det_en
        & (AW'(bul_x[i*CW +: CW]) >= x_lo)
        & (AW'(bul_x[i*CW +: CW]) <  x_hi)
        & (AW'(bul_y[i*CW +: CW]) >  y_lo)
        & (AW'(bul_y[i*CW +: CW]) <  y_hi);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hp_d    = hp_q;
    hit_d   = 1'b0;
    kill_d  = '0;
    unique case (state_q)
      S_ALIVE: begin
        kill_d = hit_vec;
        if (|hit_vec && hp_q != '0) begin
          hit_d = 1'b1;
          hp_d  = hp_q - 1'b1;
          if (hp_d == '0) begin
            state_d = S_BOOM;
            timer_d = 32'(BOOM_CYC - 1);
          end else begin
            state_d = S_INVULN;
            timer_d = 32'(INV_CYC - 1);
          end
        end
      end
      S_INVULN: begin
        kill_d = hit_vec;
        if (timer_q == '0) state_d = S_ALIVE;
        else               timer_d = timer_q - 1;
      end
      S_BOOM: begin
        if (timer_q == '0) begin
          state_d = S_REVIVE;
          timer_d = 32'(REV_CYC - 1);
          hp_d    = HP_W'(HP_MAX);
        end else begin
          timer_d = timer_q - 1;
        end
      end
      S_REVIVE: begin
        if (timer_q == '0) state_d = S_ALIVE;
        else               timer_d = timer_q - 1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ALIVE;
      timer_q <= '0;
      hp_q    <= HP_W'(HP_MAX);
      hit_q   <= 1'b0;
      kill_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      hp_q    <= hp_d;
      hit_q   <= hit_d;
      kill_q  <= kill_d;
    end
  end

  assign bul_kill = kill_q;
  assign hit      = hit_q;
  assign hp       = hp_q;
  assign boom     = (state_q == S_BOOM);
  assign revive   = (state_q == S_REVIVE);
  assign invuln   = (state_q == S_INVULN);

endmodule

// File: tb/tb_boss_hit_arbiter.sv
// Randomised and directed bench for boss_hit_arbiter against a
// remaining-cycles reference model of the boss life cycle.
module tb_boss_hit_arbiter;

  localparam int N    = 4;
  localparam int CW   = 10;
  localparam int HPW  = 4;
  localparam int HPM  = 3;
  localparam int INV  = 8;
  localparam int BOOM = 24;
  localparam int REV  = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [CW-1:0]   boss_x, boss_y;
  logic            boss_en;
  logic [N*CW-1:0] bul_x, bul_y;
  logic [N-1:0]    bul_vld;
  logic [N-1:0]    bul_kill;
  logic            hit;
  logic [HPW-1:0]  hp;
  logic            boom, revive, invuln;

  boss_hit_arbiter #(
    .N_BUL(N), .CW(CW), .HP_W(HPW), .HP_MAX(HPM),
    .BOSS_W(128), .BOSS_H(128), .BUL_W(10), .BUL_H(40),
    .Y_OFS(480), .INV_CYC(INV), .BOOM_CYC(BOOM),
    .REV_CYC(REV)
  ) dut (
    .clk(clk), .rst(rst),
    .boss_x(boss_x), .boss_y(boss_y), .boss_en(boss_en),
    .bul_x(bul_x), .bul_y(bul_y), .bul_vld(bul_vld),
    .bul_kill(bul_kill), .hit(hit), .hp(hp),
    .boom(boom), .revive(revive), .invuln(invuln)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // model: mode 0 alive, 1 invuln, 2 boom, 3 revive;
  // left = cycles still to spend in the current mode
  int m_mode, m_left, m_hp;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit in_box(int bx, int by, int x, int y);
    int yy, xl, yl;
    yy = y + 480;
    xl = (x - 10 < 0) ? 0 : x - 10;
    yl = (yy - 40 < 0) ? 0 : yy - 40;
    return bx >= xl && bx < x + 128 && by > yl && by < yy + 128;
  endfunction

  task automatic model_reset;
    m_mode = 0;
    m_left = 0;
    m_hp   = HPM;
  endtask

  task automatic set_bul(int i, int x, int y, bit v);
    bul_x[i*CW +: CW] = CW'(x);
    bul_y[i*CW +: CW] = CW'(y);
    bul_vld[i]        = v;
  endtask

  task automatic clr_bul;
    bul_x   = '0;
    bul_y   = '0;
    bul_vld = '0;
  endtask

  // Inputs are stable here; predict, clock once, compare.
  task automatic step;
    logic [N-1:0] ek;
    bit eh;
    ek = '0;
    eh = 0;
    if (m_mode <= 1 && boss_en)
      for (int i = 0; i < N; i++)
        if (bul_vld[i] &&
            in_box(int'(bul_x[i*CW +: CW]),
                   int'(bul_y[i*CW +: CW]),
                   int'(boss_x), int'(boss_y)))
          ek[i] = 1'b1;
    case (m_mode)
      0: if (ek != 0) begin
        eh = 1;
        m_hp = m_hp - 1;
        if (m_hp == 0) begin
          m_mode = 2; m_left = BOOM;
        end else begin
          m_mode = 1; m_left = INV;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
      2: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 3; m_left = REV; m_hp = HPM;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    endcase
    @(posedge clk);
    #1;
    chk("kill", 32'(bul_kill), 32'(ek));
    chk("hit", 32'(hit), 32'(eh));
    chk("hp", 32'(hp), 32'(m_hp));
    chk("boom", 32'(boom), 32'(m_mode == 2));
    chk("revive", 32'(revive), 32'(m_mode == 3));
    chk("invuln", 32'(invuln), 32'(m_mode == 1));
    @(negedge clk);
  endtask

  task automatic wait_mode(int mode);
    int n;
    n = 0;
    clr_bul();
    while (m_mode != mode && n < 200) begin
      step();
      n++;
    end
    chk("wait_mode", 32'(m_mode), 32'(mode));
  endtask

  task automatic rand_cycle;
    int x, y;
    boss_x  = CW'($urandom_range(0, 880));
    boss_y  = CW'($urandom_range(0, 400));
    boss_en = ($urandom_range(0, 7) != 0);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        x = int'(boss_x) - 15 + $urandom_range(0, 158);
        y = int'(boss_y) + 435 + $urandom_range(0, 178);
      end else begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 1023);
      end
      x = (x < 0) ? 0 : (x > 1023 ? 1023 : x);
      y = (y < 0) ? 0 : (y > 1023 ? 1023 : y);
      set_bul(i, x, y, $urandom_range(0, 3) != 0);
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    boss_x = '0;
    boss_y = '0;
    boss_en = 1'b1;
    clr_bul();
    model_reset();
    #12;
    chk("rst_hp", 32'(hp), 32'(HPM));
    chk("rst_kill", 32'(bul_kill), 32'd0);
    chk("rst_flags", {29'd0, boom, revive, invuln}, 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single hit from bullet 0
    boss_x = 10'd100;
    boss_y = 10'd0;
    set_bul(0, 150, 500, 1'b1);
    step();
    chk("t1_hit", 32'(hit), 32'd1);
    chk("t1_hp", 32'(hp), 32'(HPM - 1));
    // hits during invulnerability only consume bullets
    clr_bul();
    step();
    step();
    set_bul(2, 120, 520, 1'b1);
    step();
    wait_mode(0);

    // two channels at once cost one hp
    clr_bul();
    set_bul(1, 110, 510, 1'b1);
    set_bul(3, 200, 600, 1'b1);
    step();
    chk("t2_kill", 32'(bul_kill), 32'b1010);
    wait_mode(0);

    // inclusive left edge, exclusive right edge,
    // exclusive top edge, clamped left edge at boss_x=0
    boss_y = 10'd0;
    boss_x = 10'd100;
    set_bul(0, 228, 500, 1'b1);
    step();
    clr_bul();
    set_bul(0, 150, 440, 1'b1);
    step();
    clr_bul();
    set_bul(0, 100 - 10, 500, 1'b1);
    step();
    chk("edge_lo", 32'(bul_kill), 32'b0001);
    wait_mode(0);
    boss_x = 10'd0;
    set_bul(0, 0, 500, 1'b1);
    step();
    chk("clamp0", 32'(bul_kill), 32'b0001);
    wait_mode(0);

    // bullets parked in the hitbox while exploding
    boss_x = 10'd100;
    set_bul(0, 150, 500, 1'b1);
    for (int k = 0; k < 300 && m_mode != 3; k++) step();
    chk("revived", 32'(m_mode), 32'd3);
    wait_mode(0);

    // random traffic
    for (int k = 0; k < 3000; k++) rand_cycle();

    // asynchronous reset in the middle of BOOM
    boss_en = 1'b1;
    boss_x = 10'd100;
    boss_y = 10'd0;
    clr_bul();
    set_bul(0, 150, 500, 1'b1);
    for (int k = 0; k < 300 && m_mode != 2; k++) step();
    step();
    step();
    chk("pre_rst_boom", 32'(boom), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_boom", 32'(boom), 32'd0);
    chk("arst_hp", 32'(hp), 32'(HPM));
    chk("arst_inv", 32'(invuln), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clr_bul();
    for (int k = 0; k < 4; k++) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
